// File: rtl/fpnew_pkg.sv
// Shared FPnew types used by the divsqrt arbiter: operation, format,
// rounding-mode enumerations and the IEEE status flag struct.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [3:0] {
        FMADD  = 4'd0,
        FNMSUB = 4'd1,
        ADD    = 4'd2,
        MUL    = 4'd3,
        DIV    = 4'd4,
        SQRT   = 4'd5,
        SGNJ   = 4'd6,
        MINMAX = 4'd7,
        CMP    = 4'd8,
        CLASSIFY = 4'd9,
        F2F    = 4'd10,
        F2I    = 4'd11,
        I2F    = 4'd12,
        CPKAB  = 4'd13,
        CPKCD  = 4'd14
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_rr_arb_sel.sv
// Round-robin selector: first set bit of valid_i starting at prio_i,
// wrapping from NumReq-1 back to 0. Purely combinational.
module fpnew_rr_arb_sel #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [PtrW-1:0]   prio_i,
    output logic [PtrW-1:0]   idx_o,
    output logic              any_o
);

    logic            found;
    logic [PtrW-1:0] cand;

    // Scan requesters in rotated order and latch the first valid one.
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            cand = PtrW'((32'(prio_i) + 32'(i)) % NumReq);
            if (!found && valid_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        any_o = |valid_i;
    end

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Shares one divsqrt unit among NumReq requesters. One op in flight at a
// time; issue and response paths are combinational pass-throughs.
//   state | meaning
//   IDLE  | no op outstanding, arbitrating requesters
//   BUSY  | op issued to unit, waiting for its result
module fpnew_divsqrt_arbiter
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned WIDTH   = 64,
    parameter type         TagType = logic
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq-1:0][1:0][WIDTH-1:0] req_operands_i,
    input  operation_e                     req_op_i  [NumReq],
    input  fp_format_e                     req_fmt_i [NumReq],
    input  roundmode_e                     req_rnd_i [NumReq],
    input  TagType                         req_tag_i [NumReq],
    output logic                           unit_valid_o,
    input  logic                           unit_ready_i,
    output logic [1:0][WIDTH-1:0]          unit_operands_o,
    output operation_e                     unit_op_o,
    output fp_format_e                     unit_fmt_o,
    output roundmode_e                     unit_rnd_o,
    output TagType                         unit_tag_o,
    input  logic                           unit_out_valid_i,
    output logic                           unit_out_ready_o,
    input  logic [WIDTH-1:0]               unit_result_i,
    input  status_t                        unit_status_i,
    input  TagType                         unit_tag_i,
    output logic [NumReq-1:0]              resp_valid_o,
    input  logic [NumReq-1:0]              resp_ready_i,
    output logic [WIDTH-1:0]               resp_result_o,
    output status_t                        resp_status_o,
    output TagType                         resp_tag_o,
    input  logic                           flush_i,
    output logic                           unit_flush_o,
    output logic                           busy_o
);

    localparam int unsigned PtrW = $clog2(NumReq);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] prio_q, prio_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [PtrW-1:0] grant;
    logic            any_valid;
    logic            issue_en, resp_en;

    fpnew_rr_arb_sel #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) i_sel (
        .valid_i (req_valid_i),
        .prio_i  (prio_q),
        .idx_o   (grant),
        .any_o   (any_valid)
    );

    // Handshake steering; flush and reset silence both directions.
    always_comb begin
        issue_en         = rst_ni && (state_q == IDLE) && !flush_i;
        resp_en          = rst_ni && (state_q == BUSY) && !flush_i;
        unit_valid_o     = issue_en && any_valid;
        req_ready_o      = '0;
        if (unit_valid_o) req_ready_o[grant] = unit_ready_i;
        resp_valid_o     = '0;
        if (resp_en) resp_valid_o[owner_q] = unit_out_valid_i;
        unit_out_ready_o = resp_en && resp_ready_i[owner_q];
        unit_operands_o  = req_operands_i[grant];
        unit_op_o        = req_op_i[grant];
        unit_fmt_o       = req_fmt_i[grant];
        unit_rnd_o       = req_rnd_i[grant];
        unit_tag_o       = req_tag_i[grant];
        resp_result_o    = unit_result_i;
        resp_status_o    = unit_status_i;
        resp_tag_o       = unit_tag_i;
        unit_flush_o     = flush_i;
        busy_o           = rst_ni && (state_q == BUSY);
    end

    // Next-state: flush wins over any fire in the same cycle.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (unit_valid_o && unit_ready_i) begin
                owner_d = grant;
                prio_d  = (grant == PtrW'(NumReq - 1)) ? '0 : grant + 1'b1;
                state_d = BUSY;
            end
        end else if (unit_out_valid_i && resp_ready_i[owner_q]) begin
            state_d = IDLE;
        end
    end

    // State, pointer and owner registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Directed bench for the divsqrt arbiter: a 2-requester instance for the
// handshake/flush/reset scenarios and a 3-requester instance for rotation.
module tb_fpnew_divsqrt_arbiter;
    import fpnew_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2-requester instance
    logic [1:0]            req_valid, req_ready;
    logic [1:0][1:0][63:0] req_operands;
    operation_e            req_op  [2];
    fp_format_e            req_fmt [2];
    roundmode_e            req_rnd [2];
    logic [3:0]            req_tag [2];
    logic                  unit_valid, unit_ready;
    logic [1:0][63:0]      unit_operands;
    operation_e            unit_op;
    fp_format_e            unit_fmt;
    roundmode_e            unit_rnd;
    logic [3:0]            unit_tag;
    logic                  unit_out_valid, unit_out_ready;
    logic [63:0]           unit_result;
    status_t               unit_status;
    logic [3:0]            unit_tag_in;
    logic [1:0]            resp_valid, resp_ready;
    logic [63:0]           resp_result;
    status_t               resp_status;
    logic [3:0]            resp_tag;
    logic                  flush, unit_flush, busy;

    fpnew_divsqrt_arbiter #(.NumReq(2), .WIDTH(64), .TagType(logic [3:0])) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_operands_i(req_operands), .req_op_i(req_op), .req_fmt_i(req_fmt),
        .req_rnd_i(req_rnd), .req_tag_i(req_tag),
        .unit_valid_o(unit_valid), .unit_ready_i(unit_ready),
        .unit_operands_o(unit_operands), .unit_op_o(unit_op), .unit_fmt_o(unit_fmt),
        .unit_rnd_o(unit_rnd), .unit_tag_o(unit_tag),
        .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
        .unit_result_i(unit_result), .unit_status_i(unit_status), .unit_tag_i(unit_tag_in),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_result_o(resp_result), .resp_status_o(resp_status), .resp_tag_o(resp_tag),
        .flush_i(flush), .unit_flush_o(unit_flush), .busy_o(busy)
    );

    // 3-requester instance
    logic [2:0]            req_valid3, req_ready3;
    logic [2:0][1:0][15:0] req_operands3;
    operation_e            req_op3  [3];
    fp_format_e            req_fmt3 [3];
    roundmode_e            req_rnd3 [3];
    logic [3:0]            req_tag3 [3];
    logic                  unit_valid3, unit_ready3;
    logic [1:0][15:0]      unit_operands3;
    operation_e            unit_op3;
    fp_format_e            unit_fmt3;
    roundmode_e            unit_rnd3;
    logic [3:0]            unit_tag3;
    logic                  unit_out_valid3, unit_out_ready3;
    logic [15:0]           unit_result3;
    status_t               unit_status3;
    logic [3:0]            unit_tag_in3;
    logic [2:0]            resp_valid3, resp_ready3;
    logic [15:0]           resp_result3;
    status_t               resp_status3;
    logic [3:0]            resp_tag3;
    logic                  flush3, unit_flush3, busy3;

    fpnew_divsqrt_arbiter #(.NumReq(3), .WIDTH(16), .TagType(logic [3:0])) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_operands_i(req_operands3), .req_op_i(req_op3), .req_fmt_i(req_fmt3),
        .req_rnd_i(req_rnd3), .req_tag_i(req_tag3),
        .unit_valid_o(unit_valid3), .unit_ready_i(unit_ready3),
        .unit_operands_o(unit_operands3), .unit_op_o(unit_op3), .unit_fmt_o(unit_fmt3),
        .unit_rnd_o(unit_rnd3), .unit_tag_o(unit_tag3),
        .unit_out_valid_i(unit_out_valid3), .unit_out_ready_o(unit_out_ready3),
        .unit_result_i(unit_result3), .unit_status_i(unit_status3), .unit_tag_i(unit_tag_in3),
        .resp_valid_o(resp_valid3), .resp_ready_i(resp_ready3),
        .resp_result_o(resp_result3), .resp_status_o(resp_status3), .resp_tag_o(resp_tag3),
        .flush_i(flush3), .unit_flush_o(unit_flush3), .busy_o(busy3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] issued_tag;
        logic [3:0] tag_exp  [2];
        logic [3:0] tag3_exp [3];
        tag_exp[0]  = 4'h5; tag_exp[1]  = 4'hA;
        tag3_exp[0] = 4'h1; tag3_exp[1] = 4'h2; tag3_exp[2] = 4'h3;

        rst_n = 1'b0;
        req_valid = 2'b11; unit_ready = 1'b1; unit_out_valid = 1'b1; resp_ready = 2'b11;
        flush = 1'b0;
        req_operands[0][0] = 64'h0000_0000_0000_00A0; req_operands[0][1] = 64'h0000_0000_0000_00B0;
        req_operands[1][0] = 64'h1111_0000_0000_0001; req_operands[1][1] = 64'h1111_0000_0000_0002;
        req_op[0] = DIV;  req_op[1] = SQRT;
        req_fmt[0] = FP32; req_fmt[1] = FP64;
        req_rnd[0] = RNE; req_rnd[1] = RTZ;
        req_tag[0] = 4'h5; req_tag[1] = 4'hA;
        unit_result = 64'h0; unit_status = '0; unit_tag_in = 4'h0;
        req_valid3 = 3'b000; unit_ready3 = 1'b1; unit_out_valid3 = 1'b0; resp_ready3 = 3'b111;
        flush3 = 1'b0; unit_result3 = 16'h0; unit_status3 = '0; unit_tag_in3 = 4'h0;
        for (int i = 0; i < 3; i++) begin
            req_operands3[i][0] = 16'(i); req_operands3[i][1] = 16'(i + 8);
            req_op3[i] = DIV; req_fmt3[i] = FP16; req_rnd3[i] = RNE;
            req_tag3[i] = 4'(i + 1);
        end

        // Reset: outputs forced quiet even with active inputs
        tick(); tick();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_unit_valid", 64'(unit_valid), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_unit_out_ready", 64'(unit_out_ready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        req_valid = 2'b00; unit_out_valid = 1'b0; resp_ready = 2'b00;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'h0);

        // Only requester 1 valid, prio 0 -> grant 1, prio wraps to 0
        req_valid = 2'b10; unit_ready = 1'b1; #1;
        chk("r1_unit_valid", 64'(unit_valid), 64'h1);
        chk("r1_req_ready", 64'(req_ready), 64'h2);
        chk("r1_tag", 64'(unit_tag), 64'hA);
        chk("r1_opnd0", unit_operands[0], 64'h1111_0000_0000_0001);
        chk("r1_opnd1", unit_operands[1], 64'h1111_0000_0000_0002);
        chk("r1_op", 64'(unit_op), 64'(SQRT));
        chk("r1_fmt", 64'(unit_fmt), 64'(FP64));
        tick();
        req_valid = 2'b00; #1;
        chk("r1_busy", 64'(busy), 64'h1);
        chk("r1_prio", 64'(dut.prio_q), 64'h0);
        chk("r1_busy_unit_valid", 64'(unit_valid), 64'h0);

        // Result held while owner not ready for 4 cycles
        unit_out_valid = 1'b1; unit_result = 64'hDEAD_BEEF_0000_0001;
        unit_status = 5'b00001; unit_tag_in = 4'hA; resp_ready = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("stall_resp_valid", 64'(resp_valid), 64'h2);
            chk("stall_out_ready", 64'(unit_out_ready), 64'h0);
            chk("stall_busy", 64'(busy), 64'h1);
            tick();
        end
        chk("stall_result", resp_result, 64'hDEAD_BEEF_0000_0001);
        chk("stall_status", 64'(resp_status), 64'h1);
        resp_ready = 2'b10; #1;
        chk("stall_release", 64'(unit_out_ready), 64'h1);
        tick();
        chk("stall_idle", 64'(busy), 64'h0);
        // Stray unit result while idle is ignored
        chk("idle_stray_resp", 64'(resp_valid), 64'h0);
        chk("idle_stray_ready", 64'(unit_out_ready), 64'h0);
        unit_out_valid = 1'b0; resp_ready = 2'b00;

        // Both valid, 3-cycle unit latency -> grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            req_valid = 2'b11; unit_ready = 1'b1; #1;
            chk("alt_grant", 64'(req_ready), 64'(2'b01 << g));
            issued_tag = unit_tag;
            tick();
            chk("alt_busy", 64'(busy), 64'h1);
            for (int c = 0; c < 2; c++) begin
                chk("alt_wait", 64'(resp_valid), 64'h0);
                tick();
            end
            unit_out_valid = 1'b1; unit_tag_in = issued_tag;
            unit_result = 64'h100 + 64'(k); resp_ready = 2'b11; #1;
            chk("alt_route", 64'(resp_valid), 64'(2'b01 << g));
            chk("alt_tag", 64'(resp_tag), 64'(tag_exp[g]));
            chk("alt_result", resp_result, 64'h100 + 64'(k));
            tick();
            unit_out_valid = 1'b0;
        end
        req_valid = 2'b00; resp_ready = 2'b00;

        // Flush on the response-fire cycle
        req_valid = 2'b01; unit_ready = 1'b1; #1;
        tick();
        req_valid = 2'b00;
        unit_out_valid = 1'b1; resp_ready = 2'b11; flush = 1'b1; #1;
        chk("fl_resp_valid", 64'(resp_valid), 64'h0);
        chk("fl_out_ready", 64'(unit_out_ready), 64'h0);
        chk("fl_unit_flush", 64'(unit_flush), 64'h1);
        tick();
        flush = 1'b0; unit_out_valid = 1'b0; resp_ready = 2'b00; #1;
        chk("fl_idle", 64'(busy), 64'h0);
        chk("fl_unit_flush_low", 64'(unit_flush), 64'h0);
        chk("fl_prio", 64'(dut.prio_q), 64'h1);

        // Flush beats an issue fire
        req_valid = 2'b01; flush = 1'b1; #1;
        chk("fli_unit_valid", 64'(unit_valid), 64'h0);
        chk("fli_req_ready", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0; req_valid = 2'b00; #1;
        chk("fli_idle", 64'(busy), 64'h0);
        chk("fli_prio", 64'(dut.prio_q), 64'h1);

        // Unit not ready: grant held stable, no re-arbitration
        req_valid = 2'b11; unit_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_valid", 64'(unit_valid), 64'h1);
            chk("hold_ready", 64'(req_ready), 64'h0);
            chk("hold_tag", 64'(unit_tag), 64'hA);
            tick();
        end
        unit_ready = 1'b1; #1;
        chk("hold_fire", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00; #1;
        chk("hold_busy", 64'(busy), 64'h1);
        chk("hold_prio", 64'(dut.prio_q), 64'h0);
        unit_out_valid = 1'b1; resp_ready = 2'b10; #1;
        tick();
        unit_out_valid = 1'b0; resp_ready = 2'b00; #1;
        chk("hold_done", 64'(busy), 64'h0);

        // Reset while busy abandons the op
        req_valid = 2'b01; unit_ready = 1'b1; #1;
        tick();
        req_valid = 2'b00; #1;
        chk("mr_prio_pre", 64'(dut.prio_q), 64'h1);
        rst_n = 1'b0; #1;
        chk("mr_busy_in_rst", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1; #1;
        chk("mr_busy", 64'(busy), 64'h0);
        chk("mr_prio", 64'(dut.prio_q), 64'h0);
        unit_out_valid = 1'b1; resp_ready = 2'b11; #1;
        chk("mr_stray_resp", 64'(resp_valid), 64'h0);
        chk("mr_stray_ready", 64'(unit_out_ready), 64'h0);
        tick();
        chk("mr_still_idle", 64'(busy), 64'h0);
        unit_out_valid = 1'b0; resp_ready = 2'b00;
        req_valid = 2'b11; unit_ready = 1'b0; #1;
        chk("mr_grant0", 64'(unit_tag), 64'h5);
        req_valid = 2'b00;

        // Three requesters all valid -> 0,1,2,0,1,2 with tags echoed
        req_valid3 = 3'b111; unit_ready3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int g;
            logic [3:0] it;
            g = k % 3;
            #1;
            chk("rr3_grant", 64'(req_ready3), 64'(3'b001 << g));
            it = unit_tag3;
            tick();
            chk("rr3_busy", 64'(busy3), 64'h1);
            unit_out_valid3 = 1'b1; unit_tag_in3 = it; resp_ready3 = 3'b111; #1;
            chk("rr3_route", 64'(resp_valid3), 64'(3'b001 << g));
            chk("rr3_tag", 64'(resp_tag3), 64'(tag3_exp[g]));
            tick();
            unit_out_valid3 = 1'b0;
        end
        req_valid3 = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
